// File: rtl/decode_pkg.sv
// Shared encodings and the control-bundle type for the MIPS decode stage.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_UART0 = 6'h06;
    localparam logic [5:0] OP_UART1 = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd5;
    localparam logic [3:0] ALU_OR   = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd11;
    localparam logic [3:0] ALU_SLT  = 4'd12;

    localparam logic [1:0] DEST_RT  = 2'd0;
    localparam logic [1:0] DEST_RD  = 2'd1;
    localparam logic [1:0] DEST_RA  = 2'd2;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] WD_ALU   = 2'd0;
    localparam logic [1:0] WD_MEM   = 2'd1;
    localparam logic [1:0] WD_PC    = 2'd2;
    localparam logic [1:0] WD_UART  = 2'd3;

    localparam logic [1:0] JUMP_NONE = 2'd0;
    localparam logic [1:0] JUMP_J    = 2'd1;
    localparam logic [1:0] JUMP_JR   = 2'd2;

    typedef struct packed {
        logic [1:0] dest_sel;
        logic [3:0] alu_ctrl;
        logic [1:0] srcb_sel;
        logic [1:0] wd_sel;
        logic       reg_write;
        logic       flag_lw;
        logic       flag_sw;
        logic       type_r;
        logic       type_i;
        logic       mult_op;
        logic       mflo;
        logic       uart_flag_sel;
        logic [1:0] jump_sel;
        logic       illegal;
    } ctrl_t;

    function automatic ctrl_t ctrl_illegal();
        ctrl_t c;
        c          = '0;
        c.illegal  = 1'b1;
        c.alu_ctrl = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/decode_table.sv
// Combinational opcode/funct -> control bundle lookup.
// DECODE_UART_FLAG_EN enables the UART-flag opcodes 0x06/0x07.
module decode_table
    import decode_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_RTYPE: begin
                o_ctrl.type_r    = 1'b1;
                o_ctrl.dest_sel  = DEST_RD;
                o_ctrl.reg_write = 1'b1;
                case (i_funct)
                    FN_SLL:  o_ctrl.alu_ctrl = ALU_SLL;
                    FN_JR: begin
                        o_ctrl.jump_sel  = JUMP_JR;
                        o_ctrl.reg_write = 1'b0;
                    end
                    FN_MFLO: o_ctrl.mflo = 1'b1;
                    FN_MULT: begin
                        o_ctrl.mult_op   = 1'b1;
                        o_ctrl.reg_write = 1'b0;
                    end
                    FN_ADD:  o_ctrl.alu_ctrl = ALU_ADD;
                    FN_OR:   o_ctrl.alu_ctrl = ALU_OR;
                    FN_SLT:  o_ctrl.alu_ctrl = ALU_SLT;
                    default: o_ctrl = ctrl_illegal();
                endcase
            end
            OP_J:    o_ctrl.jump_sel = JUMP_J;
            OP_JAL: begin
                o_ctrl.jump_sel  = JUMP_J;
                o_ctrl.dest_sel  = DEST_RA;
                o_ctrl.wd_sel    = WD_PC;
                o_ctrl.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                o_ctrl.alu_ctrl = ALU_ADD;
                o_ctrl.type_i   = 1'b1;
            end
`ifdef DECODE_UART_FLAG_EN
            OP_UART0, OP_UART1: begin
                o_ctrl.wd_sel        = WD_UART;
                o_ctrl.srcb_sel      = SRCB_IMM;
                o_ctrl.alu_ctrl      = ALU_ADD;
                o_ctrl.type_i        = 1'b1;
                o_ctrl.reg_write     = 1'b1;
                o_ctrl.uart_flag_sel = i_opcode[0];
            end
`endif
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
                o_ctrl.type_i    = 1'b1;
                o_ctrl.srcb_sel  = SRCB_IMM;
                o_ctrl.reg_write = 1'b1;
                case (i_opcode)
                    OP_SLTI: o_ctrl.alu_ctrl = ALU_SLT;
                    OP_ANDI: o_ctrl.alu_ctrl = ALU_AND;
                    OP_ORI:  o_ctrl.alu_ctrl = ALU_OR;
                    OP_LUI:  o_ctrl.alu_ctrl = ALU_LUI;
                    OP_LW: begin
                        o_ctrl.alu_ctrl = ALU_ADD;
                        o_ctrl.wd_sel   = WD_MEM;
                        o_ctrl.flag_lw  = 1'b1;
                    end
                    default: o_ctrl.alu_ctrl = ALU_ADD;
                endcase
            end
            OP_SW: begin
                o_ctrl.type_i   = 1'b1;
                o_ctrl.srcb_sel = SRCB_IMM;
                o_ctrl.alu_ctrl = ALU_ADD;
                o_ctrl.flag_sw  = 1'b1;
            end
            default: o_ctrl = ctrl_illegal();
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered, valid/ready decode stage with a HI/LO scoreboard for mult/mflo.
// Optional UART-flag opcodes are enabled by DECODE_UART_FLAG_EN (see decode_table).
module decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned INSTR_W      = 32,
    parameter int unsigned MULT_LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [15:0]        imm,
    output logic [1:0]         dest_sel,
    output logic [3:0]         alu_ctrl,
    output logic [1:0]         srcb_sel,
    output logic [1:0]         wd_sel,
    output logic               reg_write,
    output logic               flag_lw,
    output logic               flag_sw,
    output logic               type_r,
    output logic               type_i,
    output logic               mult_op,
    output logic               mflo,
    output logic               uart_flag_sel,
    output logic [1:0]         jump_sel,
    output logic               illegal,
    output logic               mult_busy
);

    localparam int unsigned CNT_W = $clog2(MULT_LATENCY + 1);

    logic [31:0]      w_instr;
    ctrl_t            w_ctrl;
    logic             w_hazard;
    logic             w_accept;
    ctrl_t            r_ctrl;
    logic [25:0]      r_fields;
    logic             r_out_valid;
    logic [CNT_W-1:0] r_cnt;

    assign w_instr = in_instr[31:0];

    decode_table u_decode_table (
        .i_opcode (w_instr[31:26]),
        .i_funct  (w_instr[5:0]),
        .o_ctrl   (w_ctrl)
    );

    assign mult_busy = (r_cnt != '0);
    assign w_hazard  = mult_busy & (w_ctrl.mult_op | w_ctrl.mflo);
    assign in_ready  = (!r_out_valid | out_ready) & !w_hazard & !flush;
    assign w_accept  = in_valid & in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
            r_fields    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_ctrl;
            r_fields    <= w_instr[25:0];
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Flush never touches the counter: the multiplier is still running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_accept && w_ctrl.mult_op) begin
            r_cnt <= CNT_W'(MULT_LATENCY);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign out_valid     = r_out_valid;
    assign rs            = r_fields[25:21];
    assign rt            = r_fields[20:16];
    assign rd            = r_fields[15:11];
    assign shamt         = r_fields[10:6];
    assign imm           = r_fields[15:0];
    assign dest_sel      = r_ctrl.dest_sel;
    assign alu_ctrl      = r_ctrl.alu_ctrl;
    assign srcb_sel      = r_ctrl.srcb_sel;
    assign wd_sel        = r_ctrl.wd_sel;
    assign reg_write     = r_ctrl.reg_write;
    assign flag_lw       = r_ctrl.flag_lw;
    assign flag_sw       = r_ctrl.flag_sw;
    assign type_r        = r_ctrl.type_r;
    assign type_i        = r_ctrl.type_i;
    assign mult_op       = r_ctrl.mult_op;
    assign mflo          = r_ctrl.mflo;
    assign uart_flag_sel = r_ctrl.uart_flag_sel;
    assign jump_sel      = r_ctrl.jump_sel;
    assign illegal       = r_ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (MULT_LATENCY = 4).
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [1:0]  dest_sel, srcb_sel, wd_sel, jump_sel;
    logic [3:0]  alu_ctrl;
    logic        reg_write, flag_lw, flag_sw, type_r, type_i;
    logic        mult_op, mflo, uart_flag_sel, illegal, mult_busy;

    int n_checks = 0;
    int n_pass   = 0;

    decode_stage #(
        .INSTR_W      (32),
        .MULT_LATENCY (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .imm           (imm),
        .dest_sel      (dest_sel),
        .alu_ctrl      (alu_ctrl),
        .srcb_sel      (srcb_sel),
        .wd_sel        (wd_sel),
        .reg_write     (reg_write),
        .flag_lw       (flag_lw),
        .flag_sw       (flag_sw),
        .type_r        (type_r),
        .type_i        (type_i),
        .mult_op       (mult_op),
        .mflo          (mflo),
        .uart_flag_sel (uart_flag_sel),
        .jump_sel      (jump_sel),
        .illegal       (illegal),
        .mult_busy     (mult_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b1;
        #2 reset = 1'b0;
        tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mult_busy", 32'(mult_busy), 0);
        chk("rst_reg_write", 32'(reg_write), 0);
        chk("rst_alu", 32'(alu_ctrl), 0);
        reset = 1'b1;
        tick();

        // addi $8, $0, 5
        in_instr = 32'h2008_0005;
        in_valid = 1'b1;
        #1 chk("addi_in_ready", 32'(in_ready), 1);
        tick();
        chk("addi_valid", 32'(out_valid), 1);
        chk("addi_alu", 32'(alu_ctrl), 2);
        chk("addi_srcb", 32'(srcb_sel), 2);
        chk("addi_dest", 32'(dest_sel), 0);
        chk("addi_rt", 32'(rt), 8);
        chk("addi_imm", 32'(imm), 5);
        chk("addi_regw", 32'(reg_write), 1);
        chk("addi_type_i", 32'(type_i), 1);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", 32'(out_valid), 0);

        // mult $8,$9 then mflo $10: four stalled cycles
        in_instr = 32'h0109_0018;
        in_valid = 1'b1;
        tick();
        chk("mult_valid", 32'(out_valid), 1);
        chk("mult_op", 32'(mult_op), 1);
        chk("mult_regw", 32'(reg_write), 0);
        chk("mult_busy", 32'(mult_busy), 1);
        in_instr = 32'h0000_5012;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("mflo_stall%0d", i), 32'(in_ready), 0);
            tick();
        end
        chk("mflo_busy_low", 32'(mult_busy), 0);
        chk("mflo_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("mflo_valid", 32'(out_valid), 1);
        chk("mflo_flag", 32'(mflo), 1);
        chk("mflo_rd", 32'(rd), 10);
        chk("mflo_dest", 32'(dest_sel), 1);
        chk("mflo_regw", 32'(reg_write), 1);
        tick();

        // Backpressure: add held while or waits
        out_ready = 1'b0;
        in_instr  = 32'h012A_4020;
        in_valid  = 1'b1;
        tick();
        chk("add_valid", 32'(out_valid), 1);
        in_instr = 32'h014B_6025;
        for (int i = 0; i < 3; i++) begin
            #1 chk($sformatf("bp_ready%0d", i), 32'(in_ready), 0);
            chk($sformatf("bp_rd%0d", i), 32'(rd), 8);
            chk($sformatf("bp_alu%0d", i), 32'(alu_ctrl), 2);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        chk("or_alu", 32'(alu_ctrl), 6);
        chk("or_rd", 32'(rd), 12);

        // jal, lw, illegal opcode 0x3F back to back
        in_instr = 32'h0C00_0010;
        tick();
        chk("jal_jump", 32'(jump_sel), 1);
        chk("jal_dest", 32'(dest_sel), 2);
        chk("jal_wd", 32'(wd_sel), 2);
        in_instr = 32'h8D09_0004;
        tick();
        chk("lw_wd", 32'(wd_sel), 1);
        chk("lw_flag", 32'(flag_lw), 1);
        chk("lw_srcb", 32'(srcb_sel), 2);
        in_instr = 32'hFC00_0000;
        tick();
        chk("ill_flag", 32'(illegal), 1);
        chk("ill_regw", 32'(reg_write), 0);
        chk("ill_jump", 32'(jump_sel), 0);
        chk("ill_alu", 32'(alu_ctrl), 2);

        // Flush alongside a new instruction while the multiplier runs
        in_instr = 32'h0109_0018;
        tick();
        in_instr = 32'h2008_0005;
        flush    = 1'b1;
        #1 chk("flush_ready", 32'(in_ready), 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_busy3", 32'(mult_busy), 1);
        tick();
        tick();
        chk("flush_busy1", 32'(mult_busy), 1);
        tick();
        chk("flush_busy0", 32'(mult_busy), 0);

        // Reset in the middle of an mflo stall with a held bundle
        out_ready = 1'b0;
        in_instr  = 32'h0109_0018;
        in_valid  = 1'b1;
        tick();
        in_instr = 32'h0000_5012;
        #1 chk("rstmid_stall", 32'(in_ready), 0);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_valid", 32'(out_valid), 0);
        chk("rstmid_busy", 32'(mult_busy), 0);
        chk("rstmid_mult_op", 32'(mult_op), 0);
        chk("rstmid_rs", 32'(rs), 0);
        chk("rstmid_illegal", 32'(illegal), 0);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();

        // UART-flag opcodes
        in_instr = 32'h1800_0000;
        in_valid = 1'b1;
        tick();
`ifdef DECODE_UART_FLAG_EN
        chk("uart6_wd", 32'(wd_sel), 3);
        chk("uart6_illegal", 32'(illegal), 0);
        chk("uart6_sel", 32'(uart_flag_sel), 0);
`else
        chk("uart6_illegal", 32'(illegal), 1);
        chk("uart6_wd", 32'(wd_sel), 0);
        chk("uart6_regw", 32'(reg_write), 0);
`endif
        in_instr = 32'h1C00_0000;
        tick();
`ifdef DECODE_UART_FLAG_EN
        chk("uart7_sel", 32'(uart_flag_sel), 1);
`else
        chk("uart7_illegal", 32'(illegal), 1);
        chk("uart7_sel", 32'(uart_flag_sel), 0);
`endif
        in_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
